// File: rtl/alu_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_mc_if
// Brief   : Execute-stage ALU control bus: decode inputs, operands, md results
// Revision: 1.0 - initial release
// ============================================================================
interface alu_ctrl_mc_if #(
   parameter int WIDTH = 32
) ();
   logic [3:0]       ALUOp;
   logic [5:0]       funct;
   logic             start;
   logic [WIDTH-1:0] srcA;
   logic [WIDTH-1:0] srcB;
   logic [3:0]       aluCtrl;
   logic             stall;
   logic [WIDTH-1:0] mdResult;
   logic             mdDone;
   logic             divByZero;

   modport master (
      output ALUOp, funct, start, srcA, srcB,
      input  aluCtrl, stall, mdResult, mdDone, divByZero
   );

   modport slave (
      input  ALUOp, funct, start, srcA, srcB,
      output aluCtrl, stall, mdResult, mdDone, divByZero
   );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_mc
// Brief   : ALU op decode plus iterative unsigned mul/div/mod with pipeline stall
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctrl_mc #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input wire          clk,
   input wire          rst,
   alu_ctrl_mc_if.slave bus
);

   localparam logic [1:0]    C_OP_MUL = 2'b01;
   localparam logic [1:0]    C_OP_DIV = 2'b10;
   localparam logic [CW-1:0] C_LAST   = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_result;
   logic             r_done;
   logic             r_dbz;

   logic [3:0]       w_ctrl;
   logic             w_is_md;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_diff;
   logic             w_fits;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_x_nxt;
   logic [WIDTH-1:0] w_y_nxt;
   logic [WIDTH-1:0] w_res_nxt;

   always_comb begin
      w_ctrl = 4'd0;
      case (bus.ALUOp)
         4'd0: begin
            case (bus.funct)
               6'b100000: w_ctrl = 4'd0;
               6'b100010: w_ctrl = 4'd1;
               6'b100100: w_ctrl = 4'd2;
               6'b100101: w_ctrl = 4'd3;
               6'b100110: w_ctrl = 4'd4;
               6'b000000: w_ctrl = 4'd5;
               6'b000010: w_ctrl = 4'd6;
               6'b011000: w_ctrl = 4'd13;
               6'b011010: w_ctrl = 4'd14;
               6'b011011: w_ctrl = 4'd15;
               default:   w_ctrl = 4'd0;
            endcase
         end
         4'd1:    w_ctrl = 4'd0;
         4'd2:    w_ctrl = 4'd2;
         4'd3:    w_ctrl = 4'd3;
         4'd4:    w_ctrl = 4'd7;
         4'd5:    w_ctrl = 4'd8;
         4'd6:    w_ctrl = 4'd9;
         4'd7:    w_ctrl = 4'd10;
         4'd8:    w_ctrl = 4'd11;
         4'd9:    w_ctrl = 4'd12;
         4'd10:   w_ctrl = 4'd13;
         4'd11:   w_ctrl = 4'd14;
         4'd12:   w_ctrl = 4'd15;
         default: w_ctrl = 4'd0;
      endcase
   end

   assign w_is_md = (w_ctrl >= 4'd13);

   // Restoring-divide step: shift next dividend bit into the partial remainder.
   // A successful trial leaves a remainder below the divisor, so WIDTH bits suffice.
   assign w_trial = {r_acc, r_x[WIDTH-1]};
   assign w_fits  = (w_trial >= {1'b0, r_y});
   assign w_diff  = w_trial[WIDTH-1:0] - r_y;

   always_comb begin
      w_acc_nxt = r_acc;
      w_x_nxt   = r_x;
      w_y_nxt   = r_y;
      w_res_nxt = r_acc;
      if (r_op == C_OP_MUL) begin
         w_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
         w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
         w_y_nxt   = {1'b0, r_y[WIDTH-1:1]};
         w_res_nxt = w_acc_nxt;
      end else begin
         w_acc_nxt = w_fits ? w_diff : w_trial[WIDTH-1:0];
         w_x_nxt   = {r_x[WIDTH-2:0], w_fits};
         w_y_nxt   = r_y;
         w_res_nxt = (r_op == C_OP_DIV) ? w_x_nxt : w_acc_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_acc    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start && w_is_md) begin
                  r_op    <= w_ctrl[1:0];
                  r_x     <= bus.srcA;
                  r_y     <= bus.srcB;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nxt;
               r_x   <= w_x_nxt;
               r_y   <= w_y_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == C_LAST) begin
                  r_result <= w_res_nxt;
                  r_dbz    <= (r_op != C_OP_MUL) && (r_y == '0);
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            // The instruction retires here, so a held start is not relaunched.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.aluCtrl   = w_ctrl;
   assign bus.stall     = (r_state == S_RUN) ||
                          ((r_state == S_IDLE) && bus.start && w_is_md);
   assign bus.mdResult  = r_result;
   assign bus.mdDone    = r_done;
   assign bus.divByZero = r_dbz;

endmodule
`default_nettype wire

// File: doc/alu_ctrl_mc.md
# alu_ctrl_mc

Multi-cycle ALU control for the processor's execute stage. Decodes ALUOp/funct into the 4-bit ALU operation code and extends the decode with unsigned multiply, divide and modulo (codes 13-15). These three operations run on an internal iterative shift-add / restoring-divide datapath, and the block stalls the processor until their result is ready. Codes 0-12 pass through in zero cycles to the combinational ALU.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- CW, 6, iteration-counter width; must satisfy 2^CW > WIDTH

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ALUOp  in  4  operation class from main control
- funct  in  6  R-type function field
- start  in  1  valid instruction present in execute this cycle
- srcA  in  WIDTH  operand A (unsigned)
- srcB  in  WIDTH  operand B (unsigned; divisor for div/mod)
- aluCtrl  out  4  decoded operation code, combinational
- stall  out  1  hold PC/pipeline; combinational
- mdResult  out  WIDTH  mul/div/mod result, registered
- mdDone  out  1  one-cycle pulse: mdResult valid
- divByZero  out  1  registered; last div/mod had srcB == 0

## Operation

**Decode** is a pure function of ALUOp/funct and is valid in every state.
- ALUOp 0 uses funct:
  - 100000→0, 100010→1, 100100→2, 100101→3, 100110→4
  - 000000→5, 000010→6
  - 011000→13 (mul), 011010→14 (div), 011011→15 (mod)
  - any other funct→0
- ALUOp 1→0, 2→2, 3→3, 4→7, 5→8, 6→9, 7→10, 8→11, 9→12.
- ALUOp 10→13, 11→14, 12→15 (immediate-source mul/div/mod).
- ALUOp 13-15→0.
- isMD = (aluCtrl ≥ 13).

**FSM** has three states: IDLE, RUN, DONE.
- IDLE: on start && isMD, latch op, srcA, srcB, clear counter → RUN. Otherwise stay.
- RUN:
  - One iteration per cycle; counter increments.
  - After iteration WIDTH-1 (counter == WIDTH-1): load mdResult, set divByZero = (op≠mul && B==0) → DONE.
- DONE: mdDone = 1 → IDLE unconditionally. start is ignored in DONE, because the same instruction retires this cycle.

**stall** = (IDLE && start && isMD) || RUN. It is low in DONE and IDLE otherwise.

**Arithmetic:**
- mul: mdResult = (A·B) mod 2^WIDTH. Shift-add, LSB-first on B, with a WIDTH-bit accumulator.
- div: restoring division, MSB-first.
  - mdResult = quotient (div) or remainder (mod).
- Divide by zero: no special case in the datapath. Restoring division yields quotient = all ones and remainder = A; both are the required results. Latency is unchanged.
- divByZero updates only at RUN→DONE and holds until the next completion. A mul completion clears it.

**Reset** (asynchronous, any state): state IDLE, counter 0, mdResult 0, mdDone 0, divByZero 0, hence stall 0. A reset during RUN aborts the operation: no mdDone, and mdResult stays 0.

## Timing
- Codes 0-12: zero latency, and stall is never asserted.
- Mul/div/mod accepted at edge E0 (the cycle before it has stall high combinationally):
  - RUN covers the cycles after edges E0 … E(WIDTH-1).
  - DONE is the cycle after edge E(WIDTH). mdDone is high and mdResult is valid there.
  - stall is high for exactly WIDTH+1 consecutive cycles.
  - The instruction occupies execute for WIDTH+2 cycles in total.
- mdResult holds its value after DONE until the next completion.
- Back-to-back mul/div: a start with isMD in the cycle immediately after DONE is accepted normally.
- The WIDTH+1 stall-cycle latency is fixed regardless of operand values, including B = 0.

## Test plan
- Decode sweep: all 16 ALUOp values plus the 10 listed functs and funct 111111 with ALUOp 0 → codes as tabulated; unlisted funct → 0; stall stays 0 for all codes 0-12.
- WIDTH=32 mul: A=0x0001_0003, B=0x0000_0005 → stall high 33 cycles, then mdDone pulse with mdResult 0x0005_000F; A=B=0xFFFF_FFFF → 0x0000_0001.
- WIDTH=8 div/mod: A=200, B=7 → div gives 28, mod gives 4; stall high 9 cycles; divByZero 0.
- Divide by zero, WIDTH=8: A=0x5A, B=0 → div gives 0xFF, mod gives 0x5A; divByZero 1. A following mul 3×4 → 12, and divByZero returns to 0.
- Reset mid-RUN: assert rst 5 cycles into a 32-bit div → stall drops at once, mdDone never pulses, mdResult 0; a fresh div afterwards completes correctly.
- Back-to-back: mul then div with start held continuously across DONE → DONE does not relaunch the first op; the second op starts the cycle after DONE; two mdDone pulses WIDTH+2 cycles apart.
